// File: rtl/image_link_pkg.sv
// Shared constants and state types for the FPGA<->Nano image link receiver.
package image_link_pkg;

    localparam int CLKS_PER_BIT_50M_9600 = 5208;
    localparam int IMG_W                 = 320;
    localparam int IMG_H                 = 240;
    localparam int NUM_PIXELS            = IMG_W * IMG_H;
    localparam int PIX_W                 = 12;
    localparam int ADDR_W                = 17;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic       {WAIT_HI, WAIT_LO}         asm_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser plus a mid-bit sampling FSM.
module uart_rx
    import image_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_50M_9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_in,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int                CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1;
    logic             line;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic             wait_high;

    // NOTE: every register here is assigned with <= so all flops update from
    // the same pre-edge values; blocking assignments would chain them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1      <= 1'b1;
            line       <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            wait_high  <= 1'b0;
        end else begin
            sync1      <= uart_in;
            line       <= sync1;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    // After a bad stop bit the line may still be low; don't
                    // mistake that for a new start bit.
                    if (wait_high) begin
                        if (line) wait_high <= 1'b0;
                    end else if (!line) begin
                        state <= START;
                    end
                end

                START: begin
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        state <= line ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        rx_byte <= {line, rx_byte[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (line) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            wait_high <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/image_receiver.sv
// Reassembles 12-bit pixels from hi/lo UART bytes and writes them sequentially
// into the frame buffer, flagging end-of-image and link errors.
module image_receiver #(
    parameter int CLKS_PER_BIT = image_link_pkg::CLKS_PER_BIT_50M_9600,
    parameter int NUM_PIXELS   = image_link_pkg::NUM_PIXELS,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               uart_in,
    output logic [image_link_pkg::PIX_W-1:0]   pixel,
    output logic [image_link_pkg::ADDR_W-1:0]  address,
    output logic                               wr_en,
    output logic                               image_done,
    output logic                               frame_err,
    output logic                               sync_err
);
    import image_link_pkg::*;

    localparam int                 TIMEOUT_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int                 TO_W        = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0]    TO_LAST     = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0]  ADDR_LAST   = ADDR_W'(NUM_PIXELS - 1);

    logic [7:0]      rx_byte;
    logic            byte_valid;
    asm_state_t      asm_state;
    logic [3:0]      nibble;
    logic [TO_W-1:0] tcnt;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clk        (clk),
        .rst        (rst),
        .uart_in    (uart_in),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            asm_state  <= WAIT_HI;
            nibble     <= '0;
            tcnt       <= '0;
            pixel      <= '0;
            address    <= '0;
            wr_en      <= 1'b0;
            image_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            image_done <= 1'b0;
            sync_err   <= 1'b0;

            // Address advances the cycle after a write so it is stable with wr_en.
            if (wr_en) address <= (address == ADDR_LAST) ? '0 : address + 1'b1;

            case (asm_state)
                WAIT_HI: begin
                    tcnt <= '0;
                    if (byte_valid) begin
                        if (rx_byte[7:4] == 4'h0) begin
                            nibble    <= rx_byte[3:0];
                            asm_state <= WAIT_LO;
                        end else begin
                            sync_err <= 1'b1;
                        end
                    end
                end

                WAIT_LO: begin
                    if (byte_valid) begin
                        pixel      <= {nibble, rx_byte};
                        wr_en      <= 1'b1;
                        image_done <= (address == ADDR_LAST);
                        asm_state  <= WAIT_HI;
                    end else if (frame_err) begin
                        asm_state <= WAIT_HI;
                    end else if (tcnt == TO_LAST) begin
                        sync_err  <= 1'b1;
                        asm_state <= WAIT_HI;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                default: asm_state <= WAIT_HI;
            endcase
        end
    end

endmodule
